// File: rtl/usb_ep_status_arb_if.sv
// Bus-side request/acknowledge bundle for the EP status RAM aux-port controller.
// The requester holds req/we/addr/wdata until it sees a one-cycle ack.
interface usb_ep_status_arb_if;
  logic        bus_req;
  logic        bus_we;
  logic [7:0]  bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_ack;
  logic [15:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    output bus_ack,
    output bus_rdata
  );
endinterface

// File: rtl/usb_ep_status_arb.sv
// Aux-port controller for the 256x16 EP status RAM: shares the port between the CSR bus
// and a range-clear engine, honouring ready backpressure and the fixed read latency.
module usb_ep_status_arb #(
  parameter bit          INIT_CLEAR = 1'b1,
  parameter int unsigned RD_LAT     = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  usb_ep_status_arb_if.slave        bus,
  input  logic                      clr_start,
  input  logic [7:0]                clr_base,
  input  logic [8:0]                clr_count,
  output logic                      clr_busy,
  output logic                      clr_done,
  output logic [7:0]                s_addr_0,
  output logic                      s_read_0,
  output logic                      s_write_0,
  output logic [15:0]               s_din_0,
  input  logic                      s_ready_0,
  input  logic [15:0]               s_dout_3
);

  localparam logic [3:0] LatLast = 4'(RD_LAT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} bus_state_e;
  typedef enum logic {StClrIdle, StClrRun} clr_state_e;

  bus_state_e  bus_state_q, bus_state_d;
  clr_state_e  clr_state_q, clr_state_d;
  logic [7:0]  s_addr_q, s_addr_d;
  logic        s_read_q, s_read_d;
  logic        s_write_q, s_write_d;
  logic [15:0] s_din_q, s_din_d;
  logic        s_clr_q, s_clr_d;      // pending aux op belongs to the clear engine
  logic [3:0]  lat_q, lat_d;
  logic [15:0] rdata_q, rdata_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [8:0]  ld_rem_q, ld_rem_d;    // clear writes still to be loaded
  logic [8:0]  rem_q, rem_d;          // clear writes still to be issued
  logic        done_q, done_d;
  logic        init_q, init_d;

  logic        issue, slot_free, bus_take, clr_take;
  logic        start_req, clr_want;
  logic [7:0]  start_base, clr_addr;
  logic [8:0]  start_cnt, clr_ld_rem;

  assign issue     = (s_read_q | s_write_q) & s_ready_0;
  assign slot_free = ~(s_read_q | s_write_q) | issue;
  assign bus_take  = (bus_state_q == StIdle) & bus.bus_req & slot_free;
  assign clr_take  = slot_free & ~bus_take & clr_want;

  // A start request (or the post-reset full clear) may load its first write immediately.
  always_comb begin
    start_req  = clr_start | init_q;
    start_base = init_q ? 8'h00 : clr_base;
    start_cnt  = init_q ? 9'd256 : clr_count;
    if (clr_state_q == StClrRun) begin
      clr_want   = (ld_rem_q != 9'd0);
      clr_addr   = ptr_q;
      clr_ld_rem = ld_rem_q;
    end else begin
      clr_want   = start_req & (start_cnt != 9'd0);
      clr_addr   = start_base;
      clr_ld_rem = start_cnt;
    end
  end

  always_comb begin
    bus_state_d = bus_state_q;
    clr_state_d = clr_state_q;
    s_addr_d    = s_addr_q;
    s_read_d    = s_read_q;
    s_write_d   = s_write_q;
    s_din_d     = s_din_q;
    s_clr_d     = s_clr_q;
    lat_d       = lat_q;
    rdata_d     = rdata_q;
    ptr_d       = ptr_q;
    ld_rem_d    = ld_rem_q;
    rem_d       = rem_q;
    done_d      = 1'b0;
    init_d      = init_q;

    if (slot_free) begin
      s_read_d  = 1'b0;
      s_write_d = 1'b0;
      s_clr_d   = 1'b0;
    end

    unique case (clr_state_q)
      StClrIdle: begin
        if (start_req) begin
          init_d = 1'b0;
          if (start_cnt == 9'd0) begin
            done_d = 1'b1;
          end else begin
            clr_state_d = StClrRun;
            ptr_d       = start_base;
            ld_rem_d    = start_cnt;
            rem_d       = start_cnt;
          end
        end
      end
      StClrRun: begin
        if (issue && s_clr_q) begin
          rem_d = rem_q - 9'd1;
          if (rem_q == 9'd1) begin
            clr_state_d = StClrIdle;
            done_d      = 1'b1;
          end
        end
      end
    endcase

    unique case (bus_state_q)
      StIdle: begin
        if (bus_take) begin
          bus_state_d = StIssue;
          s_addr_d    = bus.bus_addr;
          s_read_d    = ~bus.bus_we;
          s_write_d   = bus.bus_we;
          s_din_d     = bus.bus_wdata;
          s_clr_d     = 1'b0;
        end
      end
      StIssue: begin
        if (issue) begin
          lat_d       = 4'd0;
          bus_state_d = s_read_q ? StWait : StAck;
        end
      end
      StWait: begin
        if (lat_q == LatLast) begin
          rdata_d     = s_dout_3;
          bus_state_d = StAck;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      StAck: bus_state_d = StIdle;
    endcase

    if (clr_take) begin
      s_addr_d  = clr_addr;
      s_write_d = 1'b1;
      s_read_d  = 1'b0;
      s_clr_d   = 1'b1;
      s_din_d   = 16'h0000;
      ptr_d     = clr_addr + 8'd1;
      ld_rem_d  = clr_ld_rem - 9'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_state_q <= StIdle;
      clr_state_q <= StClrIdle;
      s_addr_q    <= 8'h00;
      s_read_q    <= 1'b0;
      s_write_q   <= 1'b0;
      s_din_q     <= 16'h0000;
      s_clr_q     <= 1'b0;
      lat_q       <= 4'd0;
      rdata_q     <= 16'h0000;
      ptr_q       <= 8'h00;
      ld_rem_q    <= 9'd0;
      rem_q       <= 9'd0;
      done_q      <= 1'b0;
      init_q      <= INIT_CLEAR;
    end else begin
      bus_state_q <= bus_state_d;
      clr_state_q <= clr_state_d;
      s_addr_q    <= s_addr_d;
      s_read_q    <= s_read_d;
      s_write_q   <= s_write_d;
      s_din_q     <= s_din_d;
      s_clr_q     <= s_clr_d;
      lat_q       <= lat_d;
      rdata_q     <= rdata_d;
      ptr_q       <= ptr_d;
      ld_rem_q    <= ld_rem_d;
      rem_q       <= rem_d;
      done_q      <= done_d;
      init_q      <= init_d;
    end
  end

  assign bus.bus_ack   = (bus_state_q == StAck);
  assign bus.bus_rdata = rdata_q;
  assign clr_busy      = (clr_state_q == StClrRun);
  assign clr_done      = done_q;
  assign s_addr_0      = s_addr_q;
  assign s_read_0      = s_read_q;
  assign s_write_0     = s_write_q;
  assign s_din_0       = s_din_q;

endmodule
